// File: rtl/control_unit_gen.sv
// Multicycle controller for the 16-bit processor: fetches from a latency-configurable
// instruction ROM, decodes the IR and drives data-memory, register-file and ALU strobes.
module control_unit_gen #(
  parameter int unsigned PC_W     = 7,
  parameter int unsigned IMEM_LAT = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [15:0]     I_Data,
  input  logic            Stall,
  input  logic            Zero_Flag,
  output logic [PC_W-1:0] I_Addr,
  output logic [PC_W-1:0] PC_Out,
  output logic [15:0]     IR_Out,
  output logic [7:0]      D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_Addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_Addr,
  output logic [3:0]      RF_Rb_Addr,
  output logic [2:0]      ALU_s0,
  output logic [3:0]      outState,
  output logic [3:0]      nextState,
  output logic            Halted,
  output logic            Illegal
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_WAIT   = 4'd1,
    S_FETCH  = 4'd2,
    S_DECODE = 4'd3,
    S_NOOP   = 4'd4,
    S_LOAD_A = 4'd5,
    S_LOAD_B = 4'd6,
    S_STORE  = 4'd7,
    S_ADD    = 4'd8,
    S_SUB    = 4'd9,
    S_JMP    = 4'd10,
    S_JZ     = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [PC_W-1:0] RST_PC    = PC_W'(RESET_PC);
  localparam logic [1:0]      WAIT_LOAD = 2'(IMEM_LAT - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            ill_q, ill_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INIT;
      pc_q    <= RST_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  // Stall freezes every register; the WAIT counter reloads on any entry into WAIT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    if (!Stall) begin
      case (state_q)
        S_INIT:   state_d = S_WAIT;
        S_WAIT: begin
          if (cnt_q == 2'd0) state_d = S_FETCH;
          else               cnt_d   = cnt_q - 2'd1;
        end
        S_FETCH: begin
          ir_d    = I_Data;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
        S_DECODE: begin
          case (ir_q[15:12])
            4'd0:    state_d = S_NOOP;
            4'd1:    state_d = S_STORE;
            4'd2:    state_d = S_LOAD_A;
            4'd3:    state_d = S_ADD;
            4'd4:    state_d = S_SUB;
            4'd5:    state_d = S_HALT;
            4'd6:    state_d = S_JMP;
            4'd7:    state_d = S_JZ;
            default: begin
              state_d = S_NOOP;
              ill_d   = 1'b1;
            end
          endcase
        end
        S_LOAD_A: state_d = S_LOAD_B;
        S_JMP: begin
          pc_d    = ir_q[PC_W-1:0];
          state_d = S_WAIT;
        end
        S_JZ: begin
          if (Zero_Flag) pc_d = ir_q[PC_W-1:0];
          state_d = S_WAIT;
        end
        S_HALT:   state_d = S_HALT;
        S_LOAD_B, S_STORE, S_ADD, S_SUB, S_NOOP: state_d = S_WAIT;
        default:  state_d = S_INIT;
      endcase
      if (state_d == S_WAIT && state_q != S_WAIT) cnt_d = WAIT_LOAD;
    end
  end

  always_comb begin
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_s0     = '0;
    case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        D_Addr    = ir_q[11:4];
        RF_s      = 1'b1;
        RF_W_Addr = ir_q[3:0];
        RF_W_en   = (state_q == S_LOAD_B) && !Stall;
      end
      S_STORE: begin
        D_Addr     = ir_q[11:4];
        RF_Ra_Addr = ir_q[3:0];
        D_Wr       = !Stall;
      end
      S_ADD, S_SUB: begin
        RF_Ra_Addr = ir_q[11:8];
        RF_Rb_Addr = ir_q[7:4];
        RF_W_Addr  = ir_q[3:0];
        RF_W_en    = !Stall;
        ALU_s0     = (state_q == S_ADD) ? 3'd1 : 3'd2;
      end
      default: ;
    endcase
  end

  assign I_Addr    = pc_q;
  assign PC_Out    = pc_q;
  assign IR_Out    = ir_q;
  assign outState  = state_q;
  assign nextState = state_d;
  assign Halted    = (state_q == S_HALT);
  assign Illegal   = ill_q;

endmodule

// File: tb/tb_control_unit_gen.sv
// Directed self-checking bench for control_unit_gen across three parameter sets,
// each instance fed by its own modelled synchronous instruction ROM.
module tb_control_unit_gen;

  logic Clk;
  int   total = 0;
  int   bad   = 0;

  // Instance A: PC_W=7, IMEM_LAT=1, RESET_PC=0
  logic rst_a, stl_a, zf_a;
  logic [15:0] id_a, ir_a;
  logic [6:0] ia_a, pc_a;
  logic [7:0] da_a;
  logic dwr_a, rfs_a, rfen_a, hlt_a, ill_a;
  logic [3:0] rw_a, ra_a, rb_a, st_a, nst_a;
  logic [2:0] alu_a;
  logic [15:0] rom_a [128];

  // Instance B: PC_W=7, IMEM_LAT=3, RESET_PC=0
  logic rst_b, stl_b, zf_b;
  logic [15:0] id_b, ir_b, pb1, pb2;
  logic [6:0] ia_b, pc_b;
  logic [7:0] da_b;
  logic dwr_b, rfs_b, rfen_b, hlt_b, ill_b;
  logic [3:0] rw_b, ra_b, rb_b, st_b, nst_b;
  logic [2:0] alu_b;
  logic [15:0] rom_b [128];

  // Instance C: PC_W=3, IMEM_LAT=1, RESET_PC=5
  logic rst_c, stl_c, zf_c;
  logic [15:0] id_c, ir_c;
  logic [2:0] ia_c, pc_c;
  logic [7:0] da_c;
  logic dwr_c, rfs_c, rfen_c, hlt_c, ill_c;
  logic [3:0] rw_c, ra_c, rb_c, st_c, nst_c;
  logic [2:0] alu_c;
  logic [15:0] rom_c [8];

  control_unit_gen #(.PC_W(7), .IMEM_LAT(1), .RESET_PC(0)) u_a (
    .Clk(Clk), .Reset(rst_a), .I_Data(id_a), .Stall(stl_a), .Zero_Flag(zf_a),
    .I_Addr(ia_a), .PC_Out(pc_a), .IR_Out(ir_a), .D_Addr(da_a), .D_Wr(dwr_a),
    .RF_s(rfs_a), .RF_W_Addr(rw_a), .RF_W_en(rfen_a), .RF_Ra_Addr(ra_a),
    .RF_Rb_Addr(rb_a), .ALU_s0(alu_a), .outState(st_a), .nextState(nst_a),
    .Halted(hlt_a), .Illegal(ill_a));

  control_unit_gen #(.PC_W(7), .IMEM_LAT(3), .RESET_PC(0)) u_b (
    .Clk(Clk), .Reset(rst_b), .I_Data(id_b), .Stall(stl_b), .Zero_Flag(zf_b),
    .I_Addr(ia_b), .PC_Out(pc_b), .IR_Out(ir_b), .D_Addr(da_b), .D_Wr(dwr_b),
    .RF_s(rfs_b), .RF_W_Addr(rw_b), .RF_W_en(rfen_b), .RF_Ra_Addr(ra_b),
    .RF_Rb_Addr(rb_b), .ALU_s0(alu_b), .outState(st_b), .nextState(nst_b),
    .Halted(hlt_b), .Illegal(ill_b));

  control_unit_gen #(.PC_W(3), .IMEM_LAT(1), .RESET_PC(5)) u_c (
    .Clk(Clk), .Reset(rst_c), .I_Data(id_c), .Stall(stl_c), .Zero_Flag(zf_c),
    .I_Addr(ia_c), .PC_Out(pc_c), .IR_Out(ir_c), .D_Addr(da_c), .D_Wr(dwr_c),
    .RF_s(rfs_c), .RF_W_Addr(rw_c), .RF_W_en(rfen_c), .RF_Ra_Addr(ra_c),
    .RF_Rb_Addr(rb_c), .ALU_s0(alu_c), .outState(st_c), .nextState(nst_c),
    .Halted(hlt_c), .Illegal(ill_c));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    id_a <= rom_a[ia_a];
    pb1  <= rom_b[ia_b];
    pb2  <= pb1;
    id_b <= pb2;
    id_c <= rom_c[ia_c];
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic clear_rom_a();
    for (int i = 0; i < 128; i++) rom_a[i] = 16'h0000;
  endtask

  task automatic do_reset_a();
    @(negedge Clk);
    rst_a = 1'b1;
    step(2);
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom_a();
    rom_a[0] = 16'h2053; rom_a[1] = 16'h3124; rom_a[2] = 16'h1074; rom_a[3] = 16'h5000;
    @(negedge Clk);
    rst_a = 1'b1;
    step(2);
    total++; if (pc_a !== 7'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc_a); end
    total++; if (st_a !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st_a); end
    total++; if (ir_a !== 16'h0000) begin bad++; $display("FAIL reset_ir got=%h exp=0000", ir_a); end
    total++; if ({ill_a, hlt_a} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {ill_a, hlt_a}); end
    rst_a = 1'b0;
    step(1);
    total++; if (st_a !== 4'd1) begin bad++; $display("FAIL reset_seq_wait got=%0d exp=1", st_a); end
    step(1);
    total++; if (st_a !== 4'd2) begin bad++; $display("FAIL reset_seq_fetch got=%0d exp=2", st_a); end
    step(1);
    total++; if (st_a !== 4'd3) begin bad++; $display("FAIL reset_seq_decode got=%0d exp=3", st_a); end
    total++; if (ir_a !== 16'h2053) begin bad++; $display("FAIL first_ir got=%h exp=2053", ir_a); end
    total++; if (pc_a !== 7'd1) begin bad++; $display("FAIL decode_pc got=%0d exp=1", pc_a); end
  endtask

  task automatic test_program();
    int unsigned seq[14] = '{5, 6, 1, 2, 3, 8, 1, 2, 3, 7, 1, 2, 3, 12};
    logic e_wr, e_en;
    for (int i = 0; i < 14; i++) begin
      step(1);
      e_wr = (seq[i] == 7);
      e_en = (seq[i] == 6) || (seq[i] == 8);
      total++; if (st_a !== 4'(seq[i])) begin bad++; $display("FAIL prog_state[%0d] got=%0d exp=%0d", i, st_a, seq[i]); end
      total++; if (dwr_a !== e_wr) begin bad++; $display("FAIL prog_dwr[%0d] got=%b exp=%b", i, dwr_a, e_wr); end
      total++; if (rfen_a !== e_en) begin bad++; $display("FAIL prog_rfen[%0d] got=%b exp=%b", i, rfen_a, e_en); end
      if (seq[i] == 5 || seq[i] == 6) begin
        total++; if ({da_a, rw_a, rfs_a} !== {8'h05, 4'd3, 1'b1}) begin bad++;
          $display("FAIL load_out got=%h/%0d/%b exp=05/3/1", da_a, rw_a, rfs_a); end
      end
      if (seq[i] == 8) begin
        total++; if ({ra_a, rb_a, rw_a, alu_a, rfs_a} !== {4'd1, 4'd2, 4'd4, 3'd1, 1'b0}) begin bad++;
          $display("FAIL add_out got=%0d/%0d/%0d/%0d/%b exp=1/2/4/1/0", ra_a, rb_a, rw_a, alu_a, rfs_a); end
      end
      if (seq[i] == 7) begin
        total++; if ({da_a, ra_a} !== {8'h07, 4'd4}) begin bad++;
          $display("FAIL store_out got=%h/%0d exp=07/4", da_a, ra_a); end
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      total++; if ({pc_a, hlt_a, st_a} !== {7'd4, 1'b1, 4'd12}) begin bad++;
        $display("FAIL halt_hold[%0d] got pc=%0d h=%b st=%0d exp pc=4 h=1 st=12", i, pc_a, hlt_a, st_a); end
    end
  endtask

  task automatic test_jmp();
    clear_rom_a();
    rom_a[0] = 16'h600A; rom_a[10] = 16'h2153;
    do_reset_a();
    step(4);
    total++; if (st_a !== 4'd10) begin bad++; $display("FAIL jmp_state got=%0d exp=10", st_a); end
    total++; if (nst_a !== 4'd1) begin bad++; $display("FAIL jmp_next got=%0d exp=1", nst_a); end
    step(1);
    total++; if (pc_a !== 7'd10) begin bad++; $display("FAIL jmp_pc got=%0d exp=10", pc_a); end
    step(2);
    total++; if (ir_a !== 16'h2153) begin bad++; $display("FAIL jmp_ir got=%h exp=2153", ir_a); end
    total++; if (pc_a !== 7'd11) begin bad++; $display("FAIL jmp_pc_next got=%0d exp=11", pc_a); end
  endtask

  task automatic test_jz();
    clear_rom_a();
    rom_a[0] = 16'h7003;
    zf_a = 1'b0;
    do_reset_a();
    step(4);
    total++; if (st_a !== 4'd11) begin bad++; $display("FAIL jz_state got=%0d exp=11", st_a); end
    step(1);
    total++; if (pc_a !== 7'd1) begin bad++; $display("FAIL jz_not_taken got=%0d exp=1", pc_a); end
    zf_a = 1'b1;
    do_reset_a();
    step(5);
    total++; if (pc_a !== 7'd3) begin bad++; $display("FAIL jz_taken got=%0d exp=3", pc_a); end
    zf_a = 1'b0;
  endtask

  task automatic test_illegal();
    clear_rom_a();
    rom_a[0] = 16'hF000; rom_a[1] = 16'h0000; rom_a[2] = 16'h2053;
    do_reset_a();
    step(4);
    total++; if ({st_a, ill_a} !== {4'd4, 1'b1}) begin bad++; $display("FAIL illegal_set got st=%0d ill=%b exp st=4 ill=1", st_a, ill_a); end
    step(4);
    total++; if ({st_a, ill_a} !== {4'd4, 1'b1}) begin bad++; $display("FAIL illegal_sticky got st=%0d ill=%b exp st=4 ill=1", st_a, ill_a); end
    step(4);
    total++; if (st_a !== 4'd5) begin bad++; $display("FAIL reach_load_a got=%0d exp=5", st_a); end
    rst_a = 1'b1;
    step(1);
    total++; if ({st_a, pc_a, ill_a, rfen_a} !== {4'd0, 7'd0, 1'b0, 1'b0}) begin bad++;
      $display("FAIL mid_reset got st=%0d pc=%0d ill=%b en=%b exp 0/0/0/0", st_a, pc_a, ill_a, rfen_a); end
    step(1);
    total++; if (rfen_a !== 1'b0) begin bad++; $display("FAIL mid_reset_en got=%b exp=0", rfen_a); end
    rst_a = 1'b0;
  endtask

  task automatic test_lat3_stall();
    int unsigned seq[11] = '{1, 1, 1, 2, 3, 10, 1, 1, 1, 2, 3};
    for (int i = 0; i < 128; i++) rom_b[i] = 16'h0000;
    rom_b[0] = 16'h1074; rom_b[1] = 16'h600A; rom_b[10] = 16'h3124;
    @(negedge Clk);
    rst_b = 1'b1;
    step(2);
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      total++; if (st_b !== 4'(seq[i])) begin bad++; $display("FAIL lat3_state[%0d] got=%0d exp=%0d", i, st_b, seq[i]); end
    end
    step(1);
    stl_b = 1'b1;
    #1;
    total++; if ({st_b, nst_b, dwr_b, da_b} !== {4'd7, 4'd7, 1'b0, 8'h07}) begin bad++;
      $display("FAIL stall_store got st=%0d nst=%0d wr=%b da=%h exp 7/7/0/07", st_b, nst_b, dwr_b, da_b); end
    for (int i = 0; i < 4; i++) begin
      step(1);
      total++; if ({st_b, dwr_b} !== {4'd7, 1'b0}) begin bad++; $display("FAIL stall_hold[%0d] got st=%0d wr=%b exp 7/0", i, st_b, dwr_b); end
    end
    step(1);
    stl_b = 1'b0;
    #1;
    total++; if ({dwr_b, nst_b} !== {1'b1, 4'd1}) begin bad++; $display("FAIL stall_release got wr=%b nst=%0d exp 1/1", dwr_b, nst_b); end
    for (int i = 0; i < 11; i++) begin
      step(1);
      total++; if (st_b !== 4'(seq[i])) begin bad++; $display("FAIL lat3_post[%0d] got=%0d exp=%0d", i, st_b, seq[i]); end
      total++; if (dwr_b !== 1'b0) begin bad++; $display("FAIL store_once[%0d] got=%b exp=0", i, dwr_b); end
      if (i == 4) begin
        total++; if (ir_b !== 16'h600A) begin bad++; $display("FAIL lat3_ir_jmp got=%h exp=600A", ir_b); end
      end
    end
    total++; if ({ir_b, pc_b} !== {16'h3124, 7'd11}) begin bad++; $display("FAIL lat3_ir_target got=%h pc=%0d exp 3124 pc=11", ir_b, pc_b); end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_pc[4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    for (int i = 0; i < 8; i++) rom_c[i] = 16'h0000;
    @(negedge Clk);
    rst_c = 1'b1;
    step(2);
    total++; if (pc_c !== 3'd5) begin bad++; $display("FAIL wrap_reset_pc got=%0d exp=5", pc_c); end
    rst_c = 1'b0;
    step(3);
    for (int i = 0; i < 4; i++) begin
      total++; if ({st_c, pc_c} !== {4'd3, exp_pc[i]}) begin bad++;
        $display("FAIL wrap_pc[%0d] got st=%0d pc=%0d exp st=3 pc=%0d", i, st_c, pc_c, exp_pc[i]); end
      step(4);
    end
  endtask

  initial begin
    rst_a = 1'b1; stl_a = 1'b0; zf_a = 1'b0;
    rst_b = 1'b1; stl_b = 1'b0; zf_b = 1'b0;
    rst_c = 1'b1; stl_c = 1'b0; zf_c = 1'b0;
    clear_rom_a();
    for (int i = 0; i < 128; i++) rom_b[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rom_c[i] = 16'h0000;
    test_reset();
    test_program();
    test_jmp();
    test_jz();
    test_illegal();
    test_lat3_stall();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit_gen.md
Name: control_unit_gen

Overview:
Parametrised next-generation multicycle controller for the 16-bit processor. It fetches from an external synchronous instruction ROM with configurable read latency, holds the instruction in an internal IR and decodes it through an FSM. It drives datapath strobes (data memory, register file, ALU select). Beyond the previous controller it adds unconditional and zero-conditional jumps, a stall input, a sticky illegal-opcode flag and a halted status. It sits between the instruction ROM and the datapath (data RAM, register file, ALU).

Parameters:
- PC_W, 7: program counter / I_Addr width; legal range 1..12.
- IMEM_LAT, 1: instruction ROM read latency in cycles; legal range 1..4.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- I_Data  in  16  instruction ROM read data.
- Stall  in  1  freezes the FSM.
- Zero_Flag  in  1  datapath ALU-zero flag, sampled in the JZ state.
- I_Addr  out  PC_W  ROM address; equals PC_Out.
- PC_Out  out  PC_W  current PC.
- IR_Out  out  16  instruction register.
- D_Addr  out  8  data memory address.
- D_Wr  out  1  data memory write strobe.
- RF_s  out  1  register-file write mux select: 1 = memory, 0 = ALU.
- RF_W_Addr  out  4  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_Addr, RF_Rb_Addr  out  4 each  register-file read addresses.
- ALU_s0  out  3  ALU op select: 0 = pass, 1 = add, 2 = sub.
- outState, nextState  out  4 each  current and next FSM state codes.
- Halted  out  1  high while in HALT.
- Illegal  out  1  sticky; set when an undefined opcode is decoded.

Behaviour:
- Reset is synchronous and active-high. Reset has priority over Stall and applies from any state, including mid-instruction.
- On reset: PC = RESET_PC, IR = 0, state = INIT, wait counter = 0, Illegal = 0.
- All strobes, addresses and ALU_s0 default to 0 in every state unless listed below.
- State codes: INIT 0, WAIT 1, FETCH 2, DECODE 3, NOOP 4, LOAD_A 5, LOAD_B 6, STORE 7, ADD 8, SUB 9, JMP 10, JZ 11, HALT 12.
- INIT -> WAIT.
- WAIT: lasts exactly IMEM_LAT cycles; a down-counter is loaded with IMEM_LAT-1 on entry; exits to FETCH when the counter is 0.
- FETCH: IR <= I_Data, PC <= PC+1 (wraps modulo 2^PC_W); -> DECODE.
- DECODE: op = IR[15:12]. Dispatch: 0 NOOP, 1 STORE, 2 LOAD_A, 3 ADD, 4 SUB, 5 HALT, 6 JMP, 7 JZ. Opcodes 8..15 go to NOOP and set Illegal.
- LOAD_A: D_Addr = IR[11:4], RF_s = 1, RF_W_Addr = IR[3:0]; -> LOAD_B.
- LOAD_B: same outputs plus RF_W_en = 1; -> WAIT.
- STORE: D_Addr = IR[11:4], RF_Ra_Addr = IR[3:0], D_Wr = 1; -> WAIT.
- ADD / SUB: RF_Ra_Addr = IR[11:8], RF_Rb_Addr = IR[7:4], RF_W_Addr = IR[3:0], RF_W_en = 1, RF_s = 0, ALU_s0 = 1 (ADD) or 2 (SUB); -> WAIT.
- JMP: PC <= IR[PC_W-1:0]; -> WAIT.
- JZ: if Zero_Flag = 1, PC <= IR[PC_W-1:0]; otherwise PC is unchanged (it already points past the JZ instruction). -> WAIT.
- NOOP -> WAIT.
- HALT: Halted = 1; the FSM stays in HALT until Reset.
- Stall = 1 in any state:
  - state, PC, IR and wait counter hold;
  - D_Wr, RF_W_en, IR load and PC updates are suppressed;
  - address and select outputs keep their state values;
  - nextState reports the current state.
- Deassertion of Stall resumes the interrupted state for its full remaining duration.
- nextState is combinational and reflects the Stall and Zero_Flag inputs of the current cycle.
- Instruction latency, counted from FETCH through the last execute cycle, then WAIT:
  - NOOP / STORE / ADD / SUB / JMP / JZ: 3 + IMEM_LAT cycles;
  - LOAD: 4 + IMEM_LAT cycles.
- PC wrap: a FETCH at PC = 2^PC_W-1 yields PC = 0. Jump targets wider than PC_W are truncated.

Test Plan:
- Reset sequence (PC_W = 7, IMEM_LAT = 1): Reset high 2 cycles, then low -> PC_Out = 0, outState goes 0, 1, 2, 3. IR loads ROM[0] at the end of FETCH. PC_Out = 1 in DECODE.
- ROM = {2_05_3 (LOAD), 3_12_4 (ADD), 1_07_4 (STORE), 5000}:
  - LOAD: D_Addr = 0x05, RF_W_Addr = 3, RF_W_en pulses in LOAD_B only, RF_s = 1.
  - ADD: Ra = 1, Rb = 2, Rw = 4, ALU_s0 = 1.
  - STORE: D_Addr = 0x07, Ra = 4, D_Wr high exactly 1 cycle.
  - HALT: Halted = 1; PC_Out stays 4 for 20 cycles.
- JMP 6_00A at PC 0 -> after JMP, PC_Out = 10 and the next IR = ROM[10].
- JZ 7_003 at PC 0: with Zero_Flag = 0 -> PC_Out = 1; with Zero_Flag = 1 -> PC_Out = 3.
- IMEM_LAT = 3: WAIT holds 3 cycles; IR captures I_Data presented 3 cycles after the I_Addr change. Stall high for 5 cycles during STORE -> D_Wr stays 0 while stalled, then is high for exactly 1 cycle after release.
- Opcode 0xF -> Illegal = 1 and stays 1 through later instructions. Reset asserted in LOAD_A -> no RF_W_en, Illegal = 0, PC_Out = RESET_PC on the next cycle. PC_W = 3 with 8 NOOPs -> PC wraps from 7 to 0.
